host_mul_scheduler: RTL and testbench

HOST_MUL_SCHEDULER -- requirements
Module: host_mul_scheduler

---
 rtl/uart_spi_pkg.sv | 21 ++
 rtl/host_mul_scheduler_collector.sv | 65 ++++++
 rtl/host_mul_scheduler.sv | 176 +++++++++++++++++
 tb/tb_host_mul_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_spi_pkg.sv
// Shared types and constants for the host multiplier scheduler and its operand collectors.
package uart_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_START,
        ST_MUL_WAIT,
        ST_SEND_HI,
        ST_WAIT_HI,
        ST_SEND_LO,
        ST_WAIT_LO
    } state_e;

    typedef enum logic {
        SRC_UART = 1'b0,
        SRC_SPI  = 1'b1
    } src_e;

    localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

endpackage

// File: rtl/host_mul_scheduler_collector.sv
// Per-source operand collector: gathers A then B, raises pending, and drops bytes while a pair waits.
module operand_collector (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       clr,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       pending,
    output logic       overrun
);

    logic       have_a_q, have_a_d;
    logic       pending_q, pending_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;

    always_comb begin
        have_a_d  = have_a_q;
        pending_d = pending_q;
        a_d       = a_q;
        b_d       = b_q;
        overrun   = 1'b0;
        if (clr) begin
            pending_d = 1'b0;
            have_a_d  = 1'b0;
            // A byte landing in the grant cycle already belongs to the next pair.
            if (rx_valid) begin
                a_d      = rx_data;
                have_a_d = 1'b1;
            end
        end else if (rx_valid) begin
            if (pending_q) begin
                overrun = 1'b1;
            end else if (!have_a_q) begin
                a_d      = rx_data;
                have_a_d = 1'b1;
            end else begin
                b_d       = rx_data;
                have_a_d  = 1'b0;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_a_q  <= 1'b0;
            pending_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            have_a_q  <= have_a_d;
            pending_q <= pending_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign op_a    = a_q;
    assign op_b    = b_q;
    assign pending = pending_q;

endmodule

// File: rtl/host_mul_scheduler.sv
// Arbitrates UART/SPI operand pairs onto one multiplier and returns each 16-bit product to its requester.
module host_mul_scheduler
    import uart_spi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    input  logic        spi_rx_valid,
    input  logic [7:0]  spi_rx_data,
    output logic        mul_start,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_product,
    input  logic        uart_tx_ready,
    output logic        uart_tx_start,
    output logic [7:0]  uart_tx_data,
    output logic        spi_tx_load,
    output logic [7:0]  spi_tx_data,
    input  logic        spi_tx_done,
    output logic        busy,
    output logic [1:0]  err_overrun,
    output logic        err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    src_e             src_q, src_d;
    src_e             prio_q, prio_d;
    src_e             grant_src;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      res_q, res_d;
    logic             seen_low_q, seen_low_d;
    logic [7:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic             uart_tx_start_q, uart_tx_start_d;
    logic [7:0]       uart_tx_data_q, uart_tx_data_d;
    logic             spi_tx_load_q, spi_tx_load_d;
    logic [7:0]       spi_tx_data_q, spi_tx_data_d;
    logic [1:0]       err_overrun_q, err_overrun_d;
    logic             err_timeout_q, err_timeout_d;

    logic       clr_u, clr_s, pend_u, pend_s, ovr_u, ovr_s;
    logic [7:0] a_u, b_u, a_s, b_s;
    logic       send_fire, tx_ack;
    logic [7:0] send_byte;

    operand_collector u_coll_uart (
        .clk(clk), .reset(reset), .rx_valid(uart_rx_valid), .rx_data(uart_rx_data), .clr(clr_u),
        .op_a(a_u), .op_b(b_u), .pending(pend_u), .overrun(ovr_u)
    );

    operand_collector u_coll_spi (
        .clk(clk), .reset(reset), .rx_valid(spi_rx_valid), .rx_data(spi_rx_data), .clr(clr_s),
        .op_a(a_s), .op_b(b_s), .pending(pend_s), .overrun(ovr_s)
    );

    assign grant_src = (pend_u && (!pend_s || prio_q == SRC_UART)) ? SRC_UART : SRC_SPI;
    // UART acknowledges a byte by dropping and then raising ready; SPI by a done pulse.
    assign tx_ack = (src_q == SRC_SPI) ? spi_tx_done : (seen_low_q && uart_tx_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            src_q           <= SRC_UART;
            prio_q          <= SRC_UART;
            cnt_q           <= '0;
            res_q           <= '0;
            seen_low_q      <= 1'b0;
            mul_a_q         <= '0;
            mul_b_q         <= '0;
            uart_tx_start_q <= 1'b0;
            uart_tx_data_q  <= '0;
            spi_tx_load_q   <= 1'b0;
            spi_tx_data_q   <= '0;
            err_overrun_q   <= '0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            prio_q          <= prio_d;
            cnt_q           <= cnt_d;
            res_q           <= res_d;
            seen_low_q      <= seen_low_d;
            mul_a_q         <= mul_a_d;
            mul_b_q         <= mul_b_d;
            uart_tx_start_q <= uart_tx_start_d;
            uart_tx_data_q  <= uart_tx_data_d;
            spi_tx_load_q   <= spi_tx_load_d;
            spi_tx_data_q   <= spi_tx_data_d;
            err_overrun_q   <= err_overrun_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        prio_d        = prio_q;
        cnt_d         = cnt_q;
        res_d         = res_q;
        seen_low_d    = seen_low_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        clr_u         = 1'b0;
        clr_s         = 1'b0;
        err_overrun_d = err_overrun_q | {ovr_s, ovr_u};
        err_timeout_d = err_timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_u || pend_s) begin
                    src_d   = grant_src;
                    prio_d  = (grant_src == SRC_UART) ? SRC_SPI : SRC_UART;
                    mul_a_d = (grant_src == SRC_UART) ? a_u : a_s;
                    mul_b_d = (grant_src == SRC_UART) ? b_u : b_s;
                    clr_u   = (grant_src == SRC_UART);
                    clr_s   = (grant_src == SRC_SPI);
                    state_d = ST_MUL_START;
                end
            end
            ST_MUL_START: begin
                cnt_d   = '0;
                state_d = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    res_d   = mul_product;
                    state_d = ST_SEND_HI;
                end else if (cnt_q == CNT_LAST) begin
                    res_d         = TIMEOUT_RESULT;
                    err_timeout_d = 1'b1;
                    state_d       = ST_SEND_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND_HI, ST_SEND_LO: begin
                if (send_fire) begin
                    seen_low_d = 1'b0;
                    state_d    = (state_q == ST_SEND_HI) ? ST_WAIT_HI : ST_WAIT_LO;
                end
            end
            ST_WAIT_HI, ST_WAIT_LO: begin
                seen_low_d = seen_low_q | ~uart_tx_ready;
                if (tx_ack) state_d = (state_q == ST_WAIT_HI) ? ST_SEND_LO : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        send_fire       = (state_q == ST_SEND_HI || state_q == ST_SEND_LO) &&
                          (src_q == SRC_SPI || uart_tx_ready);
        send_byte       = (state_q == ST_SEND_HI) ? res_q[15:8] : res_q[7:0];
        uart_tx_start_d = send_fire && (src_q == SRC_UART);
        spi_tx_load_d   = send_fire && (src_q == SRC_SPI);
        uart_tx_data_d  = uart_tx_start_d ? send_byte : uart_tx_data_q;
        spi_tx_data_d   = spi_tx_load_d ? send_byte : spi_tx_data_q;
        mul_start       = (state_q == ST_MUL_START);
        busy            = (state_q != ST_IDLE);
    end

    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign uart_tx_start = uart_tx_start_q;
    assign uart_tx_data  = uart_tx_data_q;
    assign spi_tx_load   = spi_tx_load_q;
    assign spi_tx_data   = spi_tx_data_q;
    assign err_overrun   = err_overrun_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_host_mul_scheduler.sv
// Scoreboard bench for host_mul_scheduler with behavioural multiplier, UART and SPI responders.
`timescale 1ns/1ps
module tb_host_mul_scheduler;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx_valid = 1'b0, spi_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = '0, spi_rx_data = '0;
    logic        mul_start, uart_tx_start, spi_tx_load, busy, err_timeout;
    logic [7:0]  mul_a, mul_b, uart_tx_data, spi_tx_data;
    logic [1:0]  err_overrun;
    logic        mul_done;
    logic [15:0] mul_product;
    logic        resp_done = 1'b0, stray_done = 1'b0;
    logic [15:0] resp_prod = '0;
    logic        uart_tx_ready = 1'b1, spi_tx_done = 1'b0;

    int n_cmp = 0, n_err = 0;
    logic [15:0] exp_op_q[$];
    logic [8:0]  exp_tx_q[$];
    bit model_prio = 1'b0;
    bit mul_en = 1'b1, uart_hold = 1'b0;
    int mul_delay = 0;

    assign mul_done    = resp_done | stray_done;
    assign mul_product = stray_done ? 16'h1234 : resp_prod;

    always #5 clk = ~clk;

    host_mul_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .uart_tx_ready(uart_tx_ready), .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
        .spi_tx_load(spi_tx_load), .spi_tx_data(spi_tx_data), .spi_tx_done(spi_tx_done),
        .busy(busy), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected traffic for one granted pair, in the order it must appear.
    task automatic expect_txn(input bit src, input logic [7:0] a, input logic [7:0] b, input bit tmo);
        logic [15:0] p;
        p = a * b;
        if (tmo) p = 16'hFFFF;
        exp_op_q.push_back({a, b});
        exp_tx_q.push_back({src, p[15:8]});
        exp_tx_q.push_back({src, p[7:0]});
        model_prio = ~src;
    endtask

    task automatic send(input bit u, input logic [7:0] du, input bit s, input logic [7:0] ds);
        @(negedge clk);
        uart_rx_valid = u; uart_rx_data = du;
        spi_rx_valid  = s; spi_rx_data  = ds;
        @(negedge clk);
        uart_rx_valid = 1'b0; spi_rx_valid = 1'b0;
    endtask

    task automatic pair(input bit src, input logic [7:0] a, input logic [7:0] b, input int gap, input bit tmo);
        expect_txn(src, a, b, tmo);
        send(!src, a, src, a);
        repeat (gap) @(negedge clk);
        send(!src, b, src, b);
    endtask

    task automatic both_pair(input logic [7:0] au, input logic [7:0] bu, input logic [7:0] as, input logic [7:0] bs);
        if (model_prio == 1'b0) begin
            expect_txn(1'b0, au, bu, 1'b0); expect_txn(1'b1, as, bs, 1'b0);
        end else begin
            expect_txn(1'b1, as, bs, 1'b0); expect_txn(1'b0, au, bu, 1'b0);
        end
        send(1'b1, au, 1'b1, as);
        send(1'b1, bu, 1'b1, bs);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_op_q.size() != 0 || exp_tx_q.size() != 0) && n < 600);
        check({"drained_", tag}, 64'(exp_op_q.size() + exp_tx_q.size()) | 64'(busy), 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes an output.
    initial begin
        logic [15:0] eo;
        logic [8:0]  et;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mul_start) begin
                    if (exp_op_q.size() == 0) check("mul_start_unexpected", 64'(mul_start), 64'd0);
                    else begin
                        eo = exp_op_q.pop_front();
                        check("mul_a", 64'(mul_a), 64'(eo[15:8]));
                        check("mul_b", 64'(mul_b), 64'(eo[7:0]));
                    end
                end
                if (uart_tx_start || spi_tx_load) begin
                    if (exp_tx_q.size() == 0) check("tx_strobe_unexpected", 64'({uart_tx_start, spi_tx_load}), 64'd0);
                    else begin
                        et = exp_tx_q.pop_front();
                        check("tx_dest", 64'({uart_tx_start, spi_tx_load}), et[8] ? 64'd1 : 64'd2);
                        check("tx_data", 64'(uart_tx_start ? uart_tx_data : spi_tx_data), 64'(et[7:0]));
                    end
                end
            end
        end
    end

    // Multiplier model.
    initial begin
        logic [15:0] p;
        int d;
        forever begin
            @(negedge clk);
            if (reset && mul_start && mul_en) begin
                p = mul_a * mul_b;
                d = (mul_delay != 0) ? mul_delay : int'($urandom_range(1, 6));
                repeat (d) @(negedge clk);
                resp_prod = p; resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    // UART transmitter model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && uart_tx_start) begin
                uart_tx_ready = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                while (uart_hold) @(negedge clk);
                uart_tx_ready = 1'b1;
            end
        end
    end

    // SPI slave model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && spi_tx_load) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                spi_tx_done = 1'b1;
                @(negedge clk);
                spi_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sc, gap;
        logic [7:0] a, b, c, d;

        repeat (3) @(negedge clk);
        check("reset_outputs", {mul_start, mul_a, mul_b, uart_tx_start, uart_tx_data, spi_tx_load,
                                spi_tx_data, busy, err_overrun, err_timeout}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        mul_delay = 3;
        pair(1'b0, 8'h0C, 8'h0D, 0, 1'b0);
        wait_idle("uart_basic");
        pair(1'b1, 8'hFF, 8'hFF, 2, 1'b0);
        wait_idle("spi_basic");
        mul_delay = 0;

        both_pair(8'h03, 8'h07, 8'h10, 8'h20);
        wait_idle("both_first");
        pair(1'b0, 8'h02, 8'h02, 0, 1'b0);
        wait_idle("uart_between");
        both_pair(8'h11, 8'h11, 8'h80, 8'h02);
        wait_idle("both_second");

        mul_delay = 5;
        pair(1'b1, 8'h21, 8'h03, 0, 1'b0);
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        check("busy_for_overrun", 64'(busy), 64'd1);
        pair(1'b0, 8'h0A, 8'h0B, 0, 1'b0);
        send(1'b1, 8'h55, 1'b0, 8'h00);
        check("err_overrun", 64'(err_overrun), 64'd1);
        wait_idle("overrun");
        mul_delay = 0;

        mul_en = 1'b0;
        pair(1'b0, 8'h12, 8'h05, 0, 1'b1);
        n = 0;
        while (!mul_start && n < 50) begin @(negedge clk); n++; end
        check("timeout_mul_start", 64'(mul_start), 64'd1);
        repeat (TMO) @(negedge clk);
        check("err_timeout_early", 64'(err_timeout), 64'd0);
        @(negedge clk);
        check("err_timeout_set", 64'(err_timeout), 64'd1);
        wait_idle("timeout");
        mul_en = 1'b1;

        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        repeat (10) @(negedge clk);
        check("stray_done_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            sc  = int'($urandom_range(0, 2));
            gap = int'($urandom_range(0, 3));
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            if (sc == 2) both_pair(a, b, c, d);
            else pair(sc[0], a, b, gap, 1'b0);
            wait_idle("random");
        end

        check("err_sticky", 64'({err_overrun, err_timeout}), 64'b011);

        uart_hold = 1'b1;
        pair(1'b0, 8'h12, 8'h34, 1, 1'b0);
        n = 0;
        while (exp_tx_q.size() != 1 && n < 100) begin @(negedge clk); n++; end
        check("hi_byte_sent", 64'(exp_tx_q.size()), 64'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("reset_async_outputs", {mul_start, mul_a, mul_b, uart_tx_start, uart_tx_data, spi_tx_load,
                                          spi_tx_data, busy, err_overrun, err_timeout}, 64'd0);
        exp_tx_q.delete();
        exp_op_q.delete();
        model_prio = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        uart_hold = 1'b0;
        repeat (30) @(negedge clk);
        check("after_reset_idle", 64'({busy, err_overrun, err_timeout}), 64'd0);

        both_pair(8'h09, 8'h09, 8'h04, 8'h04);
        wait_idle("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
